// File: rtl/mem_pkg.sv
// Shared types and constants for the processor-to-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } mem_state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [7:0] ERR_DATA = 8'hFF;

    localparam int unsigned DEF_DEPTH   = 64;
    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational four-way round-robin pick: first requester found scanning
// upward from ptr, wrapping modulo 4.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] idx;

    // Scan ptr, ptr+1, ... and keep the first requesting index.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!any && req[idx]) begin
                gnt_idx = idx;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_mem_responder.sv
// Responder for the shared processor memory bus: round-robin grant to one of
// four requesters, a single read or write on the on-chip memory, and a
// one-cycle completion pulse on the shared return bus.
module shared_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    output logic [3:0]        ack,
    output logic              busy,
    input  logic              valid,
    input  logic              rw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_mem,
    output logic              addr_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mem_state_e        state;
    mem_state_e        state_next;
    logic [1:0]        ptr;
    logic [1:0]        g;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        arb_idx;
    logic              arb_any;

    logic              grant_load;
    logic              access;
    logic              release_grant;

    logic              in_range;
    logic              is_write;
    logic [IDX_W-1:0]  mem_idx;

    logic [DATA_W-1:0] mem [DEPTH];

    rr_arbiter4 u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    assign in_range = (address < ADDR_W'(DEPTH));
    assign is_write = (rw == RW_WRITE);
    assign mem_idx  = address[IDX_W-1:0];

    // Next-state logic and state-decoded bus outputs.
    always_comb begin
        state_next    = state;
        grant_load    = 1'b0;
        access        = 1'b0;
        release_grant = 1'b0;
        busy          = (state != IDLE);
        ack           = (state != IDLE) ? (4'b0001 << g) : '0;
        valid_mem     = (state == RESP);
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_load = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // valid takes priority over a simultaneous drop or timeout.
                if (valid) begin
                    access     = 1'b1;
                    state_next = RESP;
                end else if (!req[g] || (cnt == CNT_W'(TIMEOUT - 1))) begin
                    release_grant = 1'b1;
                    state_next    = IDLE;
                end
            end
            RESP: begin
                release_grant = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, grant bookkeeping, timeout counter and return-bus registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            g        <= '0;
            cnt      <= '0;
            data_out <= '0;
            addr_err <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_load) begin
                g   <= arb_idx;
                cnt <= '0;
            end else if (state == GRANT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (release_grant) begin
                ptr <= g + 2'd1;
            end
            if (access) begin
                addr_err <= !in_range;
                if (!in_range) begin
                    data_out <= DATA_W'(ERR_DATA);
                end else if (is_write) begin
                    data_out <= data_in;
                end else begin
                    data_out <= mem[mem_idx];
                end
            end else begin
                addr_err <= 1'b0;
            end
        end
    end

    // Memory array, not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && access && is_write && in_range) begin
            mem[mem_idx] <= data_in;
        end
    end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Randomised scoreboard bench for shared_mem_responder.
module tb_shared_mem_responder;
    import mem_pkg::*;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] ack;
    logic       busy;
    logic       valid = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] address = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       valid_mem;
    logic       addr_err;

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mdl [64];
    int         mptr = 0;

    always #5 clk = ~clk;

    shared_mem_responder #(
        .DEPTH   (64),
        .ADDR_W  (8),
        .DATA_W  (8),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ack       (ack),
        .busy      (busy),
        .valid     (valid),
        .rw        (rw),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_mem (valid_mem),
        .addr_err  (addr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        if (reset) begin
            chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
            if (valid_mem) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid_mem", 32'(valid_mem), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_data", 32'(data_out), 32'(e.data));
                    chk("resp_addr_err", 32'(addr_err), 32'(e.err));
                    chk("resp_ack", 32'(ack), 32'(e.ack));
                    chk("resp_busy", 32'(busy), 32'd1);
                end
            end else begin
                chk("addr_err_no_resp", 32'(addr_err), 32'd0);
            end
        end
    end

    // mode: 0 normal access, 1 drop req after dly cycles, 2 never assert valid
    task automatic do_access(input logic [3:0] mask, input logic wr, input logic [7:0] a,
                             input logic [7:0] d, input int mode, input int dly,
                             input bit drop_with_valid);
        int         g;
        int         w;
        int         n;
        logic [3:0] oh;
        exp_t       e;
        g = -1;
        for (int i = 0; i < 4; i++) begin
            if (g < 0 && mask[(mptr + i) % 4]) g = (mptr + i) % 4;
        end
        oh  = 4'b0001 << g;
        req = mask;
        w   = 0;
        do begin
            @(negedge clk);
            w++;
        end while (ack == '0 && w < 10);
        chk("grant_latency", 32'(w), 32'd1);
        chk("grant_winner", 32'(ack), 32'(oh));
        if (ack == '0) begin
            req = '0;
            @(negedge clk);
            return;
        end
        if (mode == 2) begin
            n = 1;
            forever begin
                @(negedge clk);
                if (ack == '0 || n > 40) break;
                n++;
            end
            chk("timeout_ack_cycles", 32'(n), 32'(TMO));
            mptr = (g + 1) % 4;
            return;
        end
        repeat (dly) @(negedge clk);
        if (mode == 1) begin
            req = mask & ~oh;
            @(negedge clk);
            chk("drop_abort_ack", 32'(ack), 32'd0);
            chk("drop_abort_busy", 32'(busy), 32'd0);
            mptr = (g + 1) % 4;
            return;
        end
        valid   = 1'b1;
        rw      = wr;
        address = a;
        data_in = d;
        if (drop_with_valid) req = mask & ~oh;
        e.ack = oh;
        if (a >= 8'd64) begin
            e.data = 8'hFF;
            e.err  = 1'b1;
        end else begin
            e.err = 1'b0;
            if (wr) begin
                mdl[a[5:0]] = d;
                e.data      = d;
            end else begin
                e.data = mdl[a[5:0]];
            end
        end
        sb.push_back(e);
        @(negedge clk);
        valid   = 1'b0;
        rw      = 1'($urandom);
        address = 8'($urandom);
        data_in = 8'($urandom);
        req     = mask & ~oh;
        @(negedge clk);
        chk("post_resp_ack", 32'(ack), 32'd0);
        mptr = (g + 1) % 4;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req   = '0;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mptr  = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid_mem", 32'(valid_mem), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        reset = 1'b1;
        mptr  = 0;

        // Basic write then read back from processor 0.
        do_access(4'b0001, 1'b1, 8'h05, 8'hA5, 0, 0, 1'b0);
        do_access(4'b0001, 1'b0, 8'h05, 8'h00, 0, 1, 1'b0);

        // All four requesting from ptr=0: 0,1,2,3,0,1,2,3.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            do_access(4'b1111, 1'b1, 8'(8 + i), 8'($urandom), 0, i % 3, 1'b0);
        end

        // Populate every location so later reads are defined.
        for (int i = 0; i < 64; i++) begin
            do_access(4'($urandom_range(1, 15)), 1'b1, 8'(i), 8'($urandom), 0, 0, 1'b0);
        end

        // Out-of-range read and write; location 0 must be untouched.
        do_access(4'b0010, 1'b0, 8'h40, 8'h00, 0, 0, 1'b0);
        do_access(4'b0010, 1'b1, 8'h40, 8'h5A, 0, 0, 1'b0);
        do_access(4'b0010, 1'b0, 8'h00, 8'h00, 0, 0, 1'b0);
        do_access(4'b1000, 1'b0, 8'hFF, 8'h00, 0, 2, 1'b0);

        // Timeout abort, then the other requester is served.
        do_access(4'b0011, 1'b0, 8'h00, 8'h00, 2, 0, 1'b0);
        do_access(4'b0011, 1'b0, 8'h01, 8'h00, 0, 0, 1'b0);

        // valid in the last GRANT cycle beats the timeout.
        do_access(4'b0100, 1'b1, 8'h20, 8'h3C, 0, TMO - 1, 1'b0);
        do_access(4'b0100, 1'b0, 8'h20, 8'h00, 0, 0, 1'b0);

        // Drop in third GRANT cycle of processor 2, then ptr must be 3.
        do_access(4'b0100, 1'b0, 8'h00, 8'h00, 1, 2, 1'b0);
        do_access(4'b1111, 1'b0, 8'h02, 8'h00, 0, 0, 1'b0);

        // valid together with a req drop still completes.
        do_access(4'b0001, 1'b1, 8'h21, 8'h77, 0, 1, 1'b1);

        // Reset coinciding with a write discards the write.
        do_access(4'b0001, 1'b1, 8'h10, 8'h11, 0, 0, 1'b0);
        req = 4'b0001;
        @(negedge clk);
        chk("rstw_grant", 32'(ack), 32'd1);
        valid   = 1'b1;
        rw      = 1'b1;
        address = 8'h10;
        data_in = 8'h22;
        reset   = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        req   = '0;
        chk("rstw_ack", 32'(ack), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_valid_mem", 32'(valid_mem), 32'd0);
        chk("rstw_addr_err", 32'(addr_err), 32'd0);
        chk("rstw_data_out", 32'(data_out), 32'd0);
        reset = 1'b1;
        mptr  = 0;
        do_access(4'b0001, 1'b0, 8'h10, 8'h00, 0, 0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            int         r;
            logic [7:0] a;
            r = int'($urandom_range(0, 9));
            a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(64, 255))
                                            : 8'($urandom_range(0, 63));
            if (r == 0) begin
                do_access(4'($urandom_range(1, 15)), 1'b0, a, 8'h00, 1,
                          int'($urandom_range(0, 5)), 1'b0);
            end else if (r == 1 && i % 4 == 0) begin
                do_access(4'($urandom_range(1, 15)), 1'b0, a, 8'h00, 2, 0, 1'b0);
            end else begin
                do_access(4'($urandom_range(1, 15)), 1'($urandom), a, 8'($urandom), 0,
                          int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0));
            end
        end

        req = '0;
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
